// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the frame-buffer BRAM port between scan-out, a frame-clear sweep and a FIFO-fed pixel writer
module fb_port_arbiter #(
  parameter int AW = 19,
  parameter int DW = 12,
  parameter int NPIX = 307200,
  parameter logic [DW-1:0] CLR_COLOR = '0,
  parameter int FDEPTH = 4
) (
  input  logic          PCK,
  input  logic          RST,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic          changescr,
  input  logic          clr_req,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          clr_busy,
  output logic          clr_overrun
);
  localparam int PW = $clog2(FDEPTH);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic armed, armed_nx;
  logic [AW-1:0] clr_ptr, clr_ptr_nx;
  logic [AW-1:0] f_addr [FDEPTH];
  logic [DW-1:0] f_data [FDEPTH];
  logic [PW:0] wp, rp;
  logic full, empty, push, gnt_rd, gnt_clr, gnt_pop, last, rd_d1;
  logic [DW-1:0] pix_q;
  assign full = (wp - rp) == (PW+1)'(FDEPTH);
  assign empty = wp == rp;
  assign wr_ready = !full && !RST;
  assign push = wr_valid && wr_ready;
  assign gnt_rd = rd_req;
  assign gnt_clr = !rd_req && state == CLEAR;
  assign gnt_pop = !rd_req && state == IDLE && !empty;
  assign last = clr_ptr == AW'(NPIX - 1);
  assign clr_busy = state == CLEAR;
  assign pix_data = pix_valid ? bram_dout : pix_q;
  // next sweep state: advance on clear grants, start or discard the armed request on frame end
  always_comb begin
    state_nx = state;
    clr_ptr_nx = clr_ptr;
    armed_nx = armed;
    if (gnt_clr) begin
      clr_ptr_nx = last ? '0 : clr_ptr + 1'b1;
      state_nx = last ? IDLE : CLEAR;
    end
    if (changescr && armed) begin
      armed_nx = 1'b0;
      if (state == IDLE) begin
        state_nx = CLEAR;
        clr_ptr_nx = '0;
      end
    end else if (clr_req) begin
      armed_nx = 1'b1;
    end
  end
  // sweep state, arm flag and sticky overrun
  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      clr_ptr <= '0;
      armed <= 1'b0;
      clr_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      clr_ptr <= clr_ptr_nx;
      armed <= armed_nx;
      if (changescr && state == CLEAR) clr_overrun <= 1'b1;
    end
  end
  // writer FIFO storage, no reset needed since pointers gate every use
  always_ff @(posedge PCK) begin
    if (push) begin
      f_addr[wp[PW-1:0]] <= wr_addr;
      f_data[wp[PW-1:0]] <= wr_data;
    end
  end
  // writer FIFO pointers
  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (PW+1)'(push);
      rp <= rp + (PW+1)'(gnt_pop);
    end
  end
  // registered BRAM port and two-stage read-valid pipeline; addr/din hold when nothing is granted
  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      bram_addr <= '0;
      bram_din <= '0;
      rd_d1 <= 1'b0;
      pix_valid <= 1'b0;
      pix_q <= '0;
    end else begin
      bram_en <= gnt_rd || gnt_clr || gnt_pop;
      bram_we <= gnt_clr || gnt_pop;
      if (gnt_rd) begin
        bram_addr <= rd_addr;
      end else if (gnt_clr) begin
        bram_addr <= clr_ptr;
        bram_din <= CLR_COLOR;
      end else if (gnt_pop) begin
        bram_addr <= f_addr[rp[PW-1:0]];
        bram_din <= f_data[rp[PW-1:0]];
      end
      rd_d1 <= gnt_rd;
      pix_valid <= rd_d1;
      if (pix_valid) pix_q <= bram_dout;
    end
  end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed tables, clear/overrun/reset sequences and a randomized run against a queue-based model
module tb_fb_port_arbiter;
  localparam int AW = 19, DW = 12, NPIX = 64, FDEPTH = 4, MW = 1024;
  logic PCK = 1'b0, RST = 1'b1;
  logic rd_req = 0, changescr = 0, clr_req = 0, wr_valid = 0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0, bram_dout;
  logic wr_ready, bram_en, bram_we, pix_valid, clr_busy, clr_overrun;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, pix_data;
  logic pl_en = 0;
  logic [9:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [MW];
  logic [DW-1:0] ref_mem [MW];
  int n_tests = 0, n_fail = 0, cnt = 0, drained = 0;

  fb_port_arbiter #(.AW(AW), .DW(DW), .NPIX(NPIX), .CLR_COLOR(12'h000), .FDEPTH(FDEPTH)) dut (
    .PCK(PCK), .RST(RST), .rd_req(rd_req), .rd_addr(rd_addr), .changescr(changescr), .clr_req(clr_req),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .pix_data(pix_data), .pix_valid(pix_valid), .clr_busy(clr_busy), .clr_overrun(clr_overrun));

  always #5 PCK = ~PCK;

  // BRAM with one-cycle read latency plus a preload path used while the DUT is held in reset
  always @(posedge PCK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bram_en && bram_we) mem[bram_addr[9:0]] <= bram_din;
    else if (bram_en) bram_dout <= mem[bram_addr[9:0]];
  end

  task automatic tick();
    @(posedge PCK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick_cnt();
    tick();
    if (bram_en && bram_we) cnt++;
  endtask

  task automatic do_reset();
    RST = 1;
    rd_req = 0; changescr = 0; clr_req = 0; wr_valid = 0;
    pl_en = 1;
    for (int i = 0; i < MW; i++) begin
      pl_addr = 10'(i);
      pl_data = (i == 100) ? 12'hABC : 12'(i * 37 + 5);
      ref_mem[i] = pl_data;
      tick();
    end
    pl_en = 0;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_clr_busy", clr_busy, 0);
    RST = 0;
    #1;
    chk("rel_wr_ready", wr_ready, 1);
  endtask

  typedef struct {logic rd; logic [AW-1:0] a; logic [DW-1:0] d;} vec_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  vec_t tbl[6];
  ent_t q[$];
  ent_t ent;
  bit m_clr, m_armed, m_ovr, e_en, e_we, s1_v, e_pv, was_clr;
  int m_ptr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, s1_d, e_pd;

  initial begin
    tbl[0] = '{1'b1, 19'd100, 12'hABC};
    tbl[1] = '{1'b0, 19'd200, 12'h123};
    tbl[2] = '{1'b1, 19'd200, 12'h123};
    tbl[3] = '{1'b0, 19'd5, 12'hFED};
    tbl[4] = '{1'b1, 19'd5, 12'hFED};
    tbl[5] = '{1'b1, 19'd7, 12'(7 * 37 + 5)};
    do_reset();
    tick();
    chk("idle_en", bram_en, 0);
    chk("idle_we", bram_we, 0);
    chk("idle_busy", clr_busy, 0);
    chk("idle_pv", pix_valid, 0);
    chk("idle_ready", wr_ready, 1);
    chk("idle_ovr", clr_overrun, 0);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rd) begin
        rd_req = 1; rd_addr = tbl[i].a;
        tick();
        rd_req = 0;
        chk("rd_en", bram_en, 1); chk("rd_we", bram_we, 0); chk("rd_addr", bram_addr, tbl[i].a);
        chk("rd_pv_n1", pix_valid, 0);
        tick();
        chk("rd_pv", pix_valid, 1); chk("rd_data", pix_data, tbl[i].d);
        tick();
        chk("rd_pv_off", pix_valid, 0); chk("rd_hold", pix_data, tbl[i].d);
      end else begin
        wr_valid = 1; wr_addr = tbl[i].a; wr_data = tbl[i].d;
        tick();
        wr_valid = 0;
        chk("wr_en_n1", bram_en, 0);
        tick();
        chk("wr_en", bram_en, 1); chk("wr_we", bram_we, 1);
        chk("wr_addr", bram_addr, tbl[i].a); chk("wr_din", bram_din, tbl[i].d);
        tick();
      end
    end
    // FIFO fills behind a held scan-out, then drains in order
    rd_req = 1; rd_addr = 0; wr_valid = 1;
    for (int k = 0; k < 4; k++) begin
      wr_addr = 19'(10 + k); wr_data = 12'(k + 1);
      chk("fifo_ready", wr_ready, 1);
      tick();
      chk("rd_only_we", bram_we, 0);
    end
    chk("fifo_full", wr_ready, 0);
    wr_addr = 19'd14; wr_data = 12'd5;
    tick();
    chk("still_full", wr_ready, 0); chk("rd_only_we", bram_we, 0);
    rd_req = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 0) chk("ready_after_pop", wr_ready, 1);
      if (j == 1) wr_valid = 0;
      chk("drain_en", bram_en, 1); chk("drain_we", bram_we, 1);
      chk("drain_addr", bram_addr, 10 + j); chk("drain_din", bram_din, j + 1);
    end
    tick();
    chk("drain_done", bram_en, 0);
    // full clear sweep with a write queued mid-sweep
    clr_req = 1; tick(); clr_req = 0;
    chk("armed_no_busy", clr_busy, 0);
    changescr = 1; tick(); changescr = 0;
    chk("clr_busy_start", clr_busy, 1);
    wr_valid = 1; wr_addr = 19'd300; wr_data = 12'h5A5;
    cnt = 0; drained = 0;
    for (int c = 0; c < NPIX + 8; c++) begin
      tick();
      wr_valid = 0;
      if (bram_en && bram_we) begin
        if (bram_addr == 19'd300) begin
          drained++;
          chk("fifo_after_clear", cnt, NPIX); chk("fifo_din", bram_din, 12'h5A5);
        end else begin
          chk("clr_addr", bram_addr, cnt); chk("clr_din", bram_din, 0);
          cnt++;
          chk("clr_busy_track", clr_busy, cnt < NPIX);
        end
      end
    end
    chk("clr_count", cnt, NPIX);
    chk("fifo_drained", drained, 1);
    chk("no_ovr", clr_overrun, 0);
    // frame end during a sweep: overrun, armed request discarded, sweep length unchanged
    clr_req = 1; tick(); clr_req = 0;
    changescr = 1; tick(); changescr = 0;
    cnt = 0;
    for (int c = 0; c < 5; c++) tick_cnt();
    clr_req = 1; tick_cnt(); clr_req = 0;
    changescr = 1; tick_cnt(); changescr = 0;
    chk("ovr_set", clr_overrun, 1);
    chk("ovr_busy", clr_busy, 1);
    for (int c = 0; c < NPIX + 20; c++) tick_cnt();
    chk("ovr_count", cnt, NPIX);
    chk("ovr_sticky", clr_overrun, 1);
    changescr = 1; tick(); changescr = 0;
    chk("no_double_clear", clr_busy, 0);
    tick();
    chk("no_double_clear2", clr_busy, 0);
    chk("ovr_sticky2", clr_overrun, 1);
    // asynchronous reset in the middle of a sweep
    clr_req = 1; tick(); clr_req = 0;
    changescr = 1; tick(); changescr = 0;
    tick(); tick();
    chk("pre_rst_busy", clr_busy, 1); chk("pre_rst_en", bram_en, 1);
    #3 RST = 1;
    #1;
    chk("arst_busy", clr_busy, 0); chk("arst_en", bram_en, 0);
    chk("arst_ovr", clr_overrun, 0); chk("arst_ready", wr_ready, 0);
    do_reset();
    // randomized run against the behavioural model
    m_clr = 0; m_armed = 0; m_ovr = 0; m_ptr = 0; q.delete();
    e_en = 0; e_we = 0; e_addr = '0; e_din = '0; s1_v = 0; s1_d = '0; e_pv = 0; e_pd = '0;
    for (int t = 0; t < 4000; t++) begin
      rd_req = $urandom_range(0, 99) < 45;
      rd_addr = AW'($urandom_range(0, MW - 1));
      wr_valid = $urandom_range(0, 99) < 50;
      wr_addr = AW'($urandom_range(0, MW - 1));
      wr_data = DW'($urandom);
      changescr = $urandom_range(0, 99) < 3;
      clr_req = $urandom_range(0, 99) < 4;
      chk("r_ready", wr_ready, q.size() < FDEPTH);
      was_clr = m_clr;
      e_pv = s1_v;
      if (s1_v) e_pd = s1_d;
      s1_v = rd_req;
      if (rd_req) s1_d = ref_mem[rd_addr[9:0]];
      if (rd_req) begin
        e_en = 1; e_we = 0; e_addr = rd_addr;
      end else if (m_clr) begin
        e_en = 1; e_we = 1; e_addr = AW'(m_ptr); e_din = '0;
        ref_mem[m_ptr] = '0;
        if (m_ptr == NPIX - 1) begin m_clr = 0; m_ptr = 0; end
        else m_ptr++;
      end else if (q.size() > 0) begin
        ent = q.pop_front();
        e_en = 1; e_we = 1; e_addr = ent.a; e_din = ent.d;
        ref_mem[ent.a[9:0]] = ent.d;
      end else begin
        e_en = 0; e_we = 0;
      end
      if (wr_valid && wr_ready) q.push_back('{wr_addr, wr_data});
      if (changescr && was_clr) m_ovr = 1;
      if (changescr && m_armed) begin
        m_armed = 0;
        if (!was_clr) begin m_clr = 1; m_ptr = 0; end
      end else if (clr_req) m_armed = 1;
      tick();
      chk("r_en", bram_en, e_en); chk("r_we", bram_we, e_we);
      chk("r_addr", bram_addr, e_addr); chk("r_din", bram_din, e_din);
      chk("r_pv", pix_valid, e_pv); chk("r_pix", pix_data, e_pd);
      chk("r_busy", clr_busy, m_clr); chk("r_ovr", clr_overrun, m_ovr);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
